// File: rtl/acc_dump_mc.sv
// Multi-channel, time-multiplexed accumulate-and-dump integrator.
// Each channel sums len signed samples, emits the sum through a one-entry valid/ready register, and then restarts.
module acc_dump_mc #(
  parameter int IN_W     = 13,
  parameter int ACC_W    = 21,
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2,
  parameter int LEN_W    = 8,
  parameter int SATURATE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [LEN_W-1:0]        len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic [CH_W-1:0]         in_chan,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic [CH_W-1:0]         out_chan,
  output logic                    out_ovf
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] acc [CHANNELS];
  logic [LEN_W-1:0]        cnt [CHANNELS];
  logic [CHANNELS-1:0]     ovf;

  logic                    accept;
  logic                    chan_ok;
  logic                    last;
  logic                    ovf_now;
  logic                    ovf_sel;
  logic signed [ACC_W-1:0] acc_sel;
  logic signed [ACC_W-1:0] result;
  logic [LEN_W-1:0]        cnt_sel;
  logic [LEN_W-1:0]        len_eff;
  logic [LEN_W:0]          cnt_next;
  logic signed [ACC_W:0]   sum;

  // The output register can drain and refill in the same cycle.
  assign in_ready = !clear && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign chan_ok  = {1'b0, in_chan} < (CH_W+1)'(CHANNELS);

  // Channel select by compare rather than array index, so unused codes never address past the array.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise unassigned paths infer latches.
    acc_sel = '0;
    cnt_sel = '0;
    ovf_sel = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (in_chan == CH_W'(c)) begin
        acc_sel = acc[c];
        cnt_sel = cnt[c];
        ovf_sel = ovf[c];
      end
    end
  end

  always_comb begin
    sum      = {acc_sel[ACC_W-1], acc_sel} + {{(ACC_W+1-IN_W){in_data[IN_W-1]}}, in_data};
    ovf_now  = sum[ACC_W] ^ sum[ACC_W-1];
    if (ovf_now && (SATURATE != 0)) begin
      result = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      result = sum[ACC_W-1:0];
    end
    len_eff  = (len == '0) ? LEN_W'(1) : len;
    cnt_next = {1'b0, cnt_sel} + (LEN_W+1)'(1);
    last     = cnt_next >= {1'b0, len_eff};
  end

  // NOTE: sequential state is written only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the per-channel arrays are small register files whose contents are architectural, so they are reset explicitly.
      for (int c = 0; c < CHANNELS; c++) begin
        acc[c] <= '0;
        cnt[c] <= '0;
      end
      ovf       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (clear) begin
        for (int c = 0; c < CHANNELS; c++) begin
          acc[c] <= '0;
          cnt[c] <= '0;
        end
        ovf <= '0;
      end else if (accept && chan_ok) begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (in_chan == CH_W'(c)) begin
            if (last) begin
              acc[c] <= '0;
              cnt[c] <= '0;
              ovf[c] <= 1'b0;
            end else begin
              acc[c] <= result;
              cnt[c] <= cnt_next[LEN_W-1:0];
              ovf[c] <= ovf[c] | ovf_now;
            end
          end
        end
      end

      if (accept && chan_ok && last) begin
        out_valid <= 1'b1;
        out_data  <= result;
        out_chan  <= in_chan;
        out_ovf   <= ovf_sel | ovf_now;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
